// File: rtl/bus_txn_ctrl_pkg.sv
// Purpose : shared types and helpers for the snoopy MSI bus transaction sequencer.
// Contents: bus_msg_t (bus message encoding), bus_state_t (sequencer states),
//           lowest_set_idx() (index of the lowest set bit of a vector).
// MAX_PROCS bounds the helper's vector width; NUM_PROCS must not exceed it.
package bus_pkg;

  localparam int unsigned MAX_PROCS = 32;

  typedef enum logic [1:0] {
    BUS_RD   = 2'b00,
    BUS_RDX  = 2'b01,
    BUS_UPGR = 2'b10,
    BUS_RSVD = 2'b11
  } bus_msg_t;

  typedef enum logic [2:0] {
    IDLE,
    BCAST,
    SNOOP,
    FLUSH,
    MEM,
    DONE
  } bus_state_t;

  // Scans from the top down so the lowest set index is the one left standing.
  function automatic int unsigned lowest_set_idx(input logic [MAX_PROCS-1:0] v);
    int unsigned idx;
    idx = 0;
    for (int unsigned i = MAX_PROCS; i > 0; i--) begin
      if (v[i-1]) idx = i - 1;
    end
    return idx;
  endfunction

endpackage

// File: rtl/bus_txn_ctrl_rr_arbiter.sv
// Purpose : combinational round-robin arbiter. Picks the first set request
//           searching upward from ptr_i with wrap-around.
// Ports   : req_i   request vector
//           ptr_i   search start index (the pointer register lives in the caller)
//           gnt_o   one-hot grant (all zero when no request)
//           idx_o   index of the granted requester
//           valid_o any request present
module rr_arbiter #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          valid_o
);

  always_comb begin
    int unsigned j;
    logic        found;
    gnt_o   = '0;
    idx_o   = '0;
    found   = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      j = 32'(ptr_i) + k;
      if (j >= N) j = j - N;
      if (!found && req_i[j]) begin
        found = 1'b1;
        gnt_o = N'(1) << j;
        idx_o = IW'(j);
      end
    end
    valid_o = found;
  end

endmodule

// File: rtl/bus_txn_ctrl.sv
// Purpose : transaction sequencer for a shared snoopy MSI bus. Arbitrates
//           round-robin, broadcasts the winner's message/address, runs the
//           snoop window, then steers the data phase (snooper flush or memory
//           read) and holds the bus until the transaction ends.
// Ports   : clk_i/rst_i (sync, active-high); req_i/msg_i/addr_i per-cache
//           request, message, address; gnt_o one-hot grant; bus_valid_o,
//           bus_msg_o, bus_addr_o, bus_owner_o broadcast; flush_i snoop
//           responses, flush_sel_o flushing cache; mem_req_o/mem_we_o/
//           mem_addr_o/mem_ack_i memory handshake; done_o completion pulse;
//           err_o watchdog pulse.
// Config  : define BUS_TIMEOUT_EN to build the memory-ack watchdog; without it
//           FLUSH/MEM wait indefinitely and err_o is tied 0.
module bus_txn_ctrl
  import bus_pkg::*;
#(
  parameter int unsigned NUM_PROCS      = 4,
  parameter int unsigned ADDR_SIZE      = 32,
  parameter int unsigned SNOOP_CYCLES   = 1,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [NUM_PROCS-1:0]           req_i,
  input  logic [2*NUM_PROCS-1:0]         msg_i,
  input  logic [ADDR_SIZE*NUM_PROCS-1:0] addr_i,
  output logic [NUM_PROCS-1:0]           gnt_o,
  output logic                           bus_valid_o,
  output logic [1:0]                     bus_msg_o,
  output logic [ADDR_SIZE-1:0]           bus_addr_o,
  output logic [$clog2(NUM_PROCS)-1:0]   bus_owner_o,
  input  logic [NUM_PROCS-1:0]           flush_i,
  output logic [NUM_PROCS-1:0]           flush_sel_o,
  output logic                           mem_req_o,
  output logic                           mem_we_o,
  output logic [ADDR_SIZE-1:0]           mem_addr_o,
  input  logic                           mem_ack_i,
  output logic [NUM_PROCS-1:0]           done_o,
  output logic                           err_o
);

  localparam int unsigned IW  = $clog2(NUM_PROCS);
  localparam int unsigned SCW = (SNOOP_CYCLES > 1) ? $clog2(SNOOP_CYCLES) : 1;

  bus_state_t           state_q, state_d;
  logic [IW-1:0]        rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]        owner_q, owner_d;
  logic [NUM_PROCS-1:0] gnt_q, gnt_d;
  bus_msg_t             msg_q, msg_d;
  logic [ADDR_SIZE-1:0] addr_q, addr_d;
  logic                 bus_valid_q, bus_valid_d;
  logic [NUM_PROCS-1:0] sticky_q, sticky_d;
  logic [NUM_PROCS-1:0] flush_sel_q, flush_sel_d;
  logic                 mem_req_q, mem_req_d;
  logic                 mem_we_q, mem_we_d;
  logic [NUM_PROCS-1:0] done_q, done_d;
  logic [SCW-1:0]       snoop_cnt_q, snoop_cnt_d;

  logic [NUM_PROCS-1:0] arb_gnt;
  logic [IW-1:0]        arb_idx;
  logic                 arb_valid;
  logic [NUM_PROCS-1:0] sticky_nx;
  logic                 go_done;

`ifdef BUS_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic          err_q, err_d;
`endif

  rr_arbiter #(.N(NUM_PROCS), .IW(IW)) u_arb (
    .req_i   (req_i),
    .ptr_i   (rr_ptr_q),
    .gnt_o   (arb_gnt),
    .idx_o   (arb_idx),
    .valid_o (arb_valid)
  );

  // Owner's own flush response is never a data source for its own request.
  assign sticky_nx = sticky_q | (flush_i & ~gnt_q);

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    owner_d     = owner_q;
    gnt_d       = gnt_q;
    msg_d       = msg_q;
    addr_d      = addr_q;
    bus_valid_d = 1'b0;
    sticky_d    = sticky_q;
    flush_sel_d = flush_sel_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    done_d      = '0;
    snoop_cnt_d = snoop_cnt_q;
    go_done     = 1'b0;
`ifdef BUS_TIMEOUT_EN
    tmo_cnt_d   = tmo_cnt_q;
    err_d       = 1'b0;
`endif

    unique case (state_q)
      IDLE: begin
        if (arb_valid) begin
          state_d     = BCAST;
          gnt_d       = arb_gnt;
          owner_d     = arb_idx;
          bus_valid_d = 1'b1;
          rr_ptr_d    = (arb_idx == IW'(NUM_PROCS - 1)) ? '0 : arb_idx + IW'(1);
          for (int unsigned p = 0; p < NUM_PROCS; p++) begin
            if (arb_gnt[p]) begin
              msg_d  = bus_msg_t'(msg_i[2*p +: 2]);
              addr_d = addr_i[ADDR_SIZE*p +: ADDR_SIZE];
            end
          end
        end
      end
      BCAST: begin
        state_d     = SNOOP;
        sticky_d    = '0;
        snoop_cnt_d = '0;
      end
      SNOOP: begin
        sticky_d = sticky_nx;
        if (snoop_cnt_q == SCW'(SNOOP_CYCLES - 1)) begin
          if (|sticky_nx) begin
            state_d     = FLUSH;
            flush_sel_d = NUM_PROCS'(1) << lowest_set_idx(MAX_PROCS'(sticky_nx));
            mem_req_d   = 1'b1;
            mem_we_d    = 1'b1;
          end else if ((msg_q == BUS_RD) || (msg_q == BUS_RDX)) begin
            state_d   = MEM;
            mem_req_d = 1'b1;
            mem_we_d  = 1'b0;
          end else begin
            go_done = 1'b1;
          end
`ifdef BUS_TIMEOUT_EN
          tmo_cnt_d = '0;
`endif
        end else begin
          snoop_cnt_d = snoop_cnt_q + SCW'(1);
        end
      end
      FLUSH, MEM: begin
        if (mem_ack_i) begin
          go_done = 1'b1;
`ifdef BUS_TIMEOUT_EN
        end else if (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
          err_d   = 1'b1;
          go_done = 1'b1;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TW'(1);
`endif
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Every path into DONE releases the bus the same way.
    if (go_done) begin
      state_d     = DONE;
      gnt_d       = '0;
      flush_sel_d = '0;
      mem_req_d   = 1'b0;
      mem_we_d    = 1'b0;
      done_d      = gnt_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      owner_q     <= '0;
      gnt_q       <= '0;
      msg_q       <= BUS_RD;
      addr_q      <= '0;
      bus_valid_q <= 1'b0;
      sticky_q    <= '0;
      flush_sel_q <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      done_q      <= '0;
      snoop_cnt_q <= '0;
`ifdef BUS_TIMEOUT_EN
      tmo_cnt_q   <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      owner_q     <= owner_d;
      gnt_q       <= gnt_d;
      msg_q       <= msg_d;
      addr_q      <= addr_d;
      bus_valid_q <= bus_valid_d;
      sticky_q    <= sticky_d;
      flush_sel_q <= flush_sel_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      done_q      <= done_d;
      snoop_cnt_q <= snoop_cnt_d;
`ifdef BUS_TIMEOUT_EN
      tmo_cnt_q   <= tmo_cnt_d;
      err_q       <= err_d;
`endif
    end
  end

  assign gnt_o       = gnt_q;
  assign bus_valid_o = bus_valid_q;
  assign bus_msg_o   = msg_q;
  assign bus_addr_o  = addr_q;
  assign bus_owner_o = owner_q;
  assign flush_sel_o = flush_sel_q;
  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = addr_q;
  assign done_o      = done_q;
`ifdef BUS_TIMEOUT_EN
  assign err_o       = err_q;
`else
  assign err_o       = 1'b0;
`endif

endmodule

// File: tb/tb_bus_txn_ctrl.sv
// Purpose : self-checking bench for bus_txn_ctrl (default parameters).
//           Directed steps plus randomized transactions, compared against a
//           transaction-level reference model. Honours BUS_TIMEOUT_EN.
module tb_bus_txn_ctrl;

  localparam int NP = 4;
  localparam int AS = 32;

  logic              clk = 1'b0;
  logic              rst_i;
  logic [NP-1:0]     req_i;
  logic [2*NP-1:0]   msg_i;
  logic [AS*NP-1:0]  addr_i;
  logic [NP-1:0]     gnt_o;
  logic              bus_valid_o;
  logic [1:0]        bus_msg_o;
  logic [AS-1:0]     bus_addr_o;
  logic [1:0]        bus_owner_o;
  logic [NP-1:0]     flush_i;
  logic [NP-1:0]     flush_sel_o;
  logic              mem_req_o;
  logic              mem_we_o;
  logic [AS-1:0]     mem_addr_o;
  logic              mem_ack_i;
  logic [NP-1:0]     done_o;
  logic              err_o;

  bus_txn_ctrl #(
    .NUM_PROCS(NP), .ADDR_SIZE(AS), .SNOOP_CYCLES(1), .TIMEOUT_CYCLES(64)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .msg_i(msg_i), .addr_i(addr_i),
    .gnt_o(gnt_o), .bus_valid_o(bus_valid_o), .bus_msg_o(bus_msg_o),
    .bus_addr_o(bus_addr_o), .bus_owner_o(bus_owner_o), .flush_i(flush_i),
    .flush_sel_o(flush_sel_o), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_ack_i(mem_ack_i), .done_o(done_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int ptr;  // model round-robin pointer

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_gnt"},   64'(gnt_o),       64'd0);
    chk({tag, "_valid"}, 64'(bus_valid_o), 64'd0);
    chk({tag, "_msg"},   64'(bus_msg_o),   64'd0);
    chk({tag, "_addr"},  64'(bus_addr_o),  64'd0);
    chk({tag, "_owner"}, 64'(bus_owner_o), 64'd0);
    chk({tag, "_fsel"},  64'(flush_sel_o), 64'd0);
    chk({tag, "_mreq"},  64'(mem_req_o),   64'd0);
    chk({tag, "_mwe"},   64'(mem_we_o),    64'd0);
    chk({tag, "_maddr"}, 64'(mem_addr_o),  64'd0);
    chk({tag, "_done"},  64'(done_o),      64'd0);
    chk({tag, "_err"},   64'(err_o),       64'd0);
  endtask

  // One full transaction. Entered and left at a negedge with the DUT in IDLE.
  // path: 0 = no data phase, 1 = snooper flush, 2 = memory read.
  task automatic run_txn(input logic [NP-1:0] req, input logic [2*NP-1:0] msgs,
                         input logic [AS*NP-1:0] addrs, input logic [NP-1:0] flush,
                         input int ack_delay);
    int w, path, fidx;
    logic [NP-1:0] oh, masked, fsel;
    logic [1:0]    emsg;
    logic [AS-1:0] eaddr;
    w = -1;
    for (int k = 0; k < NP; k++) begin
      int c;
      c = (ptr + k) % NP;
      if (w < 0 && req[c]) w = c;
    end
    ptr    = (w + 1) % NP;
    oh     = NP'(1) << w;
    emsg   = msgs[2*w +: 2];
    eaddr  = addrs[AS*w +: AS];
    masked = flush & ~oh;
    fidx   = -1;
    for (int k = NP - 1; k >= 0; k--) if (masked[k]) fidx = k;
    fsel   = (fidx >= 0) ? NP'(1) << fidx : '0;
    if (masked != 0)    path = 1;
    else if (emsg < 2)  path = 2;
    else                path = 0;

    req_i = req; msg_i = msgs; addr_i = addrs; flush_i = '0; mem_ack_i = 1'b0;
    @(negedge clk);  // broadcast cycle
    chk("bc_gnt",   64'(gnt_o),       64'(oh));
    chk("bc_valid", 64'(bus_valid_o), 64'd1);
    chk("bc_msg",   64'(bus_msg_o),   64'(emsg));
    chk("bc_addr",  64'(bus_addr_o),  64'(eaddr));
    chk("bc_owner", 64'(bus_owner_o), 64'(w));
    chk("bc_mreq",  64'(mem_req_o),   64'd0);
    req_i = NP'($urandom); mem_ack_i = 1'($urandom);
    @(negedge clk);  // snoop cycle
    chk("sn_valid", 64'(bus_valid_o), 64'd0);
    chk("sn_gnt",   64'(gnt_o),       64'(oh));
    chk("sn_mreq",  64'(mem_req_o),   64'd0);
    flush_i = flush; mem_ack_i = 1'($urandom);
    @(negedge clk);
    flush_i = '0; mem_ack_i = 1'b0;
    if (path != 0) begin
      for (int k = 0; k <= ack_delay; k++) begin
        if (k > 0) @(negedge clk);
        chk("dp_mreq",  64'(mem_req_o),   64'd1);
        chk("dp_mwe",   64'(mem_we_o),    64'(path == 1));
        chk("dp_maddr", 64'(mem_addr_o),  64'(eaddr));
        chk("dp_fsel",  64'(flush_sel_o), 64'(fsel));
        chk("dp_gnt",   64'(gnt_o),       64'(oh));
        chk("dp_done",  64'(done_o),      64'd0);
        chk("dp_err",   64'(err_o),       64'd0);
        mem_ack_i = (k == ack_delay);
      end
      @(negedge clk);
      mem_ack_i = 1'b0;
    end
    chk("dn_done", 64'(done_o),      64'(oh));
    chk("dn_gnt",  64'(gnt_o),       64'd0);
    chk("dn_mreq", 64'(mem_req_o),   64'd0);
    chk("dn_fsel", 64'(flush_sel_o), 64'd0);
    chk("dn_msg",  64'(bus_msg_o),   64'(emsg));
    chk("dn_addr", 64'(bus_addr_o),  64'(eaddr));
    chk("dn_err",  64'(err_o),       64'd0);
    @(negedge clk);  // idle
    chk("id_done", 64'(done_o), 64'd0);
    chk("id_gnt",  64'(gnt_o),  64'd0);
    req_i = '0;
  endtask

  initial begin
    rst_i = 1'b1; req_i = '0; msg_i = '0; addr_i = '0; flush_i = '0; mem_ack_i = 1'b0;
    ptr = 0;
    repeat (2) @(negedge clk);
    chk_all_zero("rst");
    rst_i = 1'b0;
    @(negedge clk);
    chk_all_zero("post_rst");

    // Round robin with all requesters held: 0,1,2,3,0.
    for (int i = 0; i < 5; i++)
      run_txn(4'hF, 8'h00, {32'h3000, 32'h2000, 32'h1000, 32'h0000}, 4'h0, 0);

    // Cache 2 BusRd @0x40, memory ack on the second MEM cycle.
    run_txn(4'b0100, 8'h00, {32'h0, 32'h40, 32'h0, 32'h0}, 4'h0, 1);
    // Cache 2 BusRdX @0x80, cache 0 flushes.
    run_txn(4'b0100, 8'h10, {32'h0, 32'h80, 32'h0, 32'h0}, 4'b0001, 0);
    // Owner 1 BusUpgr, flush 1010: own bit masked, cache 3 flushes.
    run_txn(4'b0010, 8'h08, {32'h0, 32'h0, 32'hC0, 32'h0}, 4'b1010, 2);
    // Owner 1 BusUpgr, no flush: straight to DONE.
    run_txn(4'b0010, 8'h08, {32'h0, 32'h0, 32'hC4, 32'h0}, 4'b0000, 0);
    // Owner 0 reserved message behaves like BusUpgr.
    run_txn(4'b0001, 8'h03, {32'h0, 32'h0, 32'h0, 32'hD0}, 4'b0000, 0);

    for (int i = 0; i < 30; i++)
      run_txn(NP'($urandom_range(1, 15)), 8'($urandom),
              {$urandom, $urandom, $urandom, $urandom},
              ($urandom_range(0, 2) == 0) ? NP'($urandom) : '0,
              $urandom_range(0, 3));

    // Reset while in MEM.
    req_i = 4'b0001; msg_i = 8'h00; addr_i = {4{32'h1234}};
    @(negedge clk);
    req_i = '0;
    @(negedge clk);
    @(negedge clk);
    chk("t5_mreq", 64'(mem_req_o), 64'd1);
    rst_i = 1'b1;
    @(negedge clk);
    chk_all_zero("t5");
    rst_i = 1'b0; ptr = 0;
    @(negedge clk);
    chk("t5_nodone", 64'(done_o), 64'd0);
    run_txn(4'hF, 8'h00, {32'h33, 32'h22, 32'h11, 32'h5A}, 4'h0, 0);

`ifdef BUS_TIMEOUT_EN
    req_i = 4'b0010; msg_i = 8'h04; addr_i = {4{32'h700}};
    @(negedge clk);
    req_i = '0;
    @(negedge clk);
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      chk("t6_wait_mreq", 64'(mem_req_o), 64'd1);
      chk("t6_wait_err",  64'(err_o),     64'd0);
    end
    @(negedge clk);
    chk("t6_err",  64'(err_o),     64'd1);
    chk("t6_done", 64'(done_o),    64'b0010);
    chk("t6_mreq", 64'(mem_req_o), 64'd0);
    @(negedge clk);
    chk("t6_err_clr", 64'(err_o), 64'd0);
`else
    run_txn(4'b0010, 8'h04, {32'h0, 32'h0, 32'h700, 32'h0}, 4'h0, 80);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
